reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/reg_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// reg_bus_arbiter_pkg : shared FSM encodings and requester indices
// Revision: 1.0
// ============================================================================
package reg_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic REQ_FW  = 1'b0;
    localparam logic REQ_ETH = 1'b1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : reg_bus_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin picker; on a tie the one not granted last wins
// Revision: 1.0
// ============================================================================
module rr_arb2
    import reg_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last;
        end else if (req[REQ_ETH]) begin
            grant = REQ_ETH;
        end else begin
            grant = REQ_FW;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// reg_bus_arbiter : FireWire/Ethernet arbiter onto a shared register file bus.
// Optional REG_ARB_LOCK_EN lets an owner hold the bus for up to MAX_LOCK txns.
// Revision: 1.0
// ============================================================================
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int MAX_LOCK = 64
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [1:0]  lock,
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic [15:0] reg_raddr,
    output logic [15:0] reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        reg_wen,
    input  logic [31:0] reg_rdata,
    output logic        busy,
    output logic        owner
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_wr;
    logic        r_owner;
    logic        r_prio;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_wait_cnt;
    logic [1:0]  w_req_eff;
    logic        w_grant;
    logic        w_valid;
    logic        w_take;

    assign w_take = (r_state == ST_IDLE) && w_valid;

    // r_prio is the favoured requester; the picker wants the last grantee.
    rr_arb2 u_rr_arb2 (
        .req   (w_req_eff),
        .last  (~r_prio),
        .grant (w_grant),
        .valid (w_valid)
    );

`ifdef REG_ARB_LOCK_EN
    logic       r_locked;
    logic [7:0] r_lock_cnt;
    logic [7:0] w_lock_cnt_inc;

    // r_lock_cnt stays below MAX_LOCK (<= 255), so the increment cannot wrap.
    assign w_lock_cnt_inc = (r_locked ? r_lock_cnt : 8'd0) + 8'd1;

    always_comb begin
        w_req_eff = req;
        if (r_locked && req[r_owner]) begin
            w_req_eff = req & onehot2(r_owner);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= 8'd0;
        end else if ((r_state == ST_IDLE) && r_locked && !req[r_owner]) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= 8'd0;
        end else if (r_state == ST_DONE) begin
            if (lock[r_owner] && req[r_owner] && (w_lock_cnt_inc < 8'(MAX_LOCK))) begin
                r_locked   <= 1'b1;
                r_lock_cnt <= w_lock_cnt_inc;
            end else begin
                r_locked   <= 1'b0;
                r_lock_cnt <= 8'd0;
            end
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{lock, 8'(MAX_LOCK)};
    assign w_req_eff    = req;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = r_wr ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == 3'd0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Command is captured at grant so a dropped req cannot cancel it.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_wr       <= 1'b0;
            r_owner    <= REQ_FW;
            r_prio     <= REQ_FW;
            r_addr     <= 16'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_wait_cnt <= 3'd0;
        end else begin
            if (w_take) begin
                r_owner <= w_grant;
                r_prio  <= ~w_grant;
                r_wr    <= wr[w_grant];
                r_addr  <= w_grant ? addr[31:16] : addr[15:0];
                r_wdata <= w_grant ? wdata[63:32] : wdata[31:0];
                r_rdata <= 32'd0;
            end
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= 3'(READ_LAT - 1);
            end
            if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
                if (r_wait_cnt == 3'd0) begin
                    r_rdata <= reg_rdata;
                end
            end
        end
    end

    always_comb begin
        ack     = 2'b00;
        rdata   = 32'd0;
        reg_wen = 1'b0;
        busy    = (r_state != ST_IDLE);
        if (r_state == ST_DONE) begin
            ack   = onehot2(r_owner);
            rdata = r_rdata;
        end
        if (r_state == ST_ISSUE) begin
            reg_wen = r_wr;
        end
    end

    assign reg_raddr = r_addr;
    assign reg_waddr = r_addr;
    assign reg_wdata = r_wdata;
    assign owner     = r_owner;

endmodule : reg_bus_arbiter
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_bus_arbiter : directed self-checking bench for reg_bus_arbiter
// Revision: 1.0
// ============================================================================
module tb_reg_bus_arbiter;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [1:0]  lock;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic [15:0] reg_raddr;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] reg_rdata = 32'd0;
    logic        busy;
    logic        owner;

    int errors = 0;
    int checks = 0;

    always #5 sysclk = ~sysclk;

    // Register file with one cycle of read latency: data = 0x0400_0000 | address.
    always @(posedge sysclk) reg_rdata <= 32'h0400_0000 | {16'h0000, reg_raddr};

    reg_bus_arbiter #(.READ_LAT(1), .MAX_LOCK(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .req       (req),
        .wr        (wr),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .reg_raddr (reg_raddr),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .reg_wen   (reg_wen),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b00; wr = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
        tick();
        tick();
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b expected 00", ack); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++; if (reg_raddr !== 16'd0 || reg_waddr !== 16'd0) begin
            errors++; $display("FAIL rst_addr: got r=%h w=%h expected 0", reg_raddr, reg_waddr); end
        checks++; if (reg_wdata !== 32'd0 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL rst_wr: got wdata=%h wen=%b expected 0", reg_wdata, reg_wen); end
        checks++; if (busy !== 1'b0 || owner !== 1'b0) begin
            errors++; $display("FAIL rst_busy_owner: got busy=%b owner=%b expected 0 0", busy, owner); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        req = 2'b01; wr = 2'b01;
        addr  = {16'hEEEE, 16'h0000};
        wdata = {32'hDEAD_BEEF, 32'h000C_0000};
        checks++; if (busy !== 1'b0 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL wr_n: got busy=%b wen=%b expected 0 0", busy, reg_wen); end
        tick();
        checks++; if (reg_wen !== 1'b1 || reg_waddr !== 16'h0000 || reg_wdata !== 32'h000C_0000) begin
            errors++; $display("FAIL wr_n1: got wen=%b waddr=%h wdata=%h expected 1 0000 000c0000",
                               reg_wen, reg_waddr, reg_wdata); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_n1_ack: got %b expected 00", ack); end
        req = 2'b00;
        tick();
        checks++; if (ack !== 2'b01 || rdata !== 32'd0 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL wr_n2: got ack=%b rdata=%h wen=%b expected 01 0 0", ack, rdata, reg_wen); end
        tick();
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_n3: got ack=%b busy=%b expected 00 0", ack, busy); end
    endtask

    task automatic test_read_eth();
        req = 2'b10; wr = 2'b00;
        addr = {16'h0001, 16'h0FFF};
        tick();
        checks++; if (reg_raddr !== 16'h0001 || reg_wen !== 1'b0) begin
            errors++; $display("FAIL rd_n1: got raddr=%h wen=%b expected 0001 0", reg_raddr, reg_wen); end
        req = 2'b00;
        tick();
        checks++; if (ack !== 2'b00 || reg_raddr !== 16'h0001) begin
            errors++; $display("FAIL rd_n2: got ack=%b raddr=%h expected 00 0001", ack, reg_raddr); end
        tick();
        checks++; if (ack !== 2'b10 || rdata !== 32'h0400_0001 || owner !== 1'b1) begin
            errors++; $display("FAIL rd_n3: got ack=%b rdata=%h owner=%b expected 10 04000001 1",
                               ack, rdata, owner); end
        tick();
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_n4: got ack=%b busy=%b expected 00 0", ack, busy); end
    endtask

    task automatic test_back_to_back();
        int   n = 0;
        int   budget = 0;
        logic exp_idx;
        req = 2'b11; wr = 2'b11; lock = 2'b00;
        addr  = {16'h00B1, 16'h00A0};
        wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        while (n < 8 && budget < 60) begin
            tick();
            budget++;
            exp_idx = n[0];
            if (reg_wen === 1'b1) begin
                checks++;
                if (reg_waddr !== (exp_idx ? 16'h00B1 : 16'h00A0) ||
                    reg_wdata !== (exp_idx ? 32'hBBBB_0001 : 32'hAAAA_0000)) begin
                    errors++; $display("FAIL b2b_wr%0d: got waddr=%h wdata=%h expected requester %0d",
                                       n, reg_waddr, reg_wdata, exp_idx); end
            end
            if (ack !== 2'b00) begin
                checks++;
                if (ack !== (exp_idx ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL b2b_ack%0d: got %b expected %b",
                                       n, ack, (exp_idx ? 2'b10 : 2'b01)); end
                n++;
                if (n == 8) req = 2'b00;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL b2b_count: got %0d acks expected 8", n); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_lock();
        int         n = 0;
        int         budget = 0;
        logic [4:0] exp_seq;
        logic       e;
`ifdef REG_ARB_LOCK_EN
        exp_seq = 5'b10000;
`else
        exp_seq = 5'b01010;
`endif
        req = 2'b11; wr = 2'b00; lock = 2'b01;
        addr = {16'h0021, 16'h0010};
        while (n < 5 && budget < 60) begin
            tick();
            budget++;
            if (ack !== 2'b00) begin
                e = exp_seq[n];
                checks++;
                if (ack !== (e ? 2'b10 : 2'b01) ||
                    rdata !== (e ? 32'h0400_0021 : 32'h0400_0010)) begin
                    errors++; $display("FAIL lock_grant%0d: got ack=%b rdata=%h expected requester %0d",
                                       n, ack, rdata, e); end
                n++;
                if (n == 5) begin req = 2'b00; lock = 2'b00; end
            end
        end
        checks++; if (n != 5) begin errors++; $display("FAIL lock_count: got %0d acks expected 5", n); end
        req = 2'b00; lock = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        req = 2'b10; wr = 2'b10;
        addr  = {16'h0055, 16'h0000};
        wdata = {32'h1234_5678, 32'h0000_0000};
        tick();
        checks++; if (reg_wen !== 1'b1 || reg_waddr !== 16'h0055) begin
            errors++; $display("FAIL mid_issue: got wen=%b waddr=%h expected 1 0055", reg_wen, reg_waddr); end
        reset = 1'b1; req = 2'b00;
        tick();
        checks++; if (reg_wen !== 1'b0 || ack !== 2'b00 || busy !== 1'b0 || owner !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl: got wen=%b ack=%b busy=%b owner=%b expected 0 00 0 0",
                               reg_wen, ack, busy, owner); end
        checks++; if (reg_waddr !== 16'd0 || reg_raddr !== 16'd0 || reg_wdata !== 32'd0 || rdata !== 32'd0) begin
            errors++; $display("FAIL mid_data: got waddr=%h raddr=%h wdata=%h rdata=%h expected 0",
                               reg_waddr, reg_raddr, reg_wdata, rdata); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack !== 2'b00 || reg_wen !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles expected 0", stray); end
        req = 2'b11; wr = 2'b11;
        addr  = {16'h0077, 16'h0066};
        wdata = {32'h7777_0000, 32'h6666_0000};
        tick();
        checks++; if (reg_wen !== 1'b1 || reg_waddr !== 16'h0066 || reg_wdata !== 32'h6666_0000) begin
            errors++; $display("FAIL post_rst_wr: got wen=%b waddr=%h wdata=%h expected 1 0066 66660000",
                               reg_wen, reg_waddr, reg_wdata); end
        req = 2'b00;
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL post_rst_ack: got %b expected 01", ack); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_eth();
        test_back_to_back();
        test_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000ns");
        $fatal(1);
    end

endmodule : tb_reg_bus_arbiter
`default_nettype wire
